// File: rtl/pc_pkg.sv
// Shared types and helpers for the IF-stage program-counter generator.
//   pc_state_t  : fetch FSM states
//   PC_XLEN     : default address width
//   PC_INC      : default sequential fetch increment (bytes)
//   align_vec() : clears bits [1:0] of a vector address
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } pc_state_t;

  localparam int PC_XLEN = 32;
  localparam int PC_INC  = 4;

  function automatic logic [PC_XLEN-1:0] align_vec(input logic [PC_XLEN-1:0] v);
    return {v[PC_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-fetch request bus between pc_gen and instruction memory.
//   ireq_valid_o  : fetch request valid (driven by the fetch unit)
//   iaddr_o       : fetch address, stable while valid and not accepted
//   ireq_ready_in : memory accepts the request this cycle
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int XLEN = PC_XLEN
);
  logic            ireq_valid_o;
  logic            ireq_ready_in;
  logic [XLEN-1:0] iaddr_o;

  modport master (output ireq_valid_o, output iaddr_o, input  ireq_ready_in);
  modport slave  (input  ireq_valid_o, input  iaddr_o, output ireq_ready_in);
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state selection for pc_gen.
// Priority outside BOOT: trap, then branch (FETCH only), then sequential.
//   state_i, pc_i          : current FSM state and fetch PC
//   hs_i                   : fetch handshake this cycle
//   trap_i, trap_vec_i     : trap request and vector (low 2 bits dropped)
//   branch_taken_i/target_i: redirect request from EX
//   next_pc_o, next_state_o: values for the registers at the next edge
//   kill_o                 : a redirect overrides this cycle's fetch
//   misalign_set_o         : branch target rejected
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN = PC_XLEN,
  parameter int INC  = PC_INC
) (
  input  pc_state_t       state_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            hs_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output pc_state_t       next_state_o,
  output logic            kill_o,
  output logic            misalign_set_o
);

  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

  logic [XLEN-1:0] tvec_al;

  generate
    if (XLEN == PC_XLEN) begin : g_pkg_align
      assign tvec_al = align_vec(trap_vec_i);
    end else begin : g_slice_align
      assign tvec_al = {trap_vec_i[XLEN-1:2], 2'b00};
    end
  endgenerate

  always_comb begin
    next_pc_o      = pc_i;
    next_state_o   = state_i;
    kill_o         = 1'b0;
    misalign_set_o = 1'b0;
    if (state_i == BOOT) begin
      next_state_o = FETCH;
    end else if (trap_i) begin
      next_pc_o    = tvec_al;
      next_state_o = FETCH;
      kill_o       = 1'b1;
    end else if (state_i == FETCH && branch_taken_i) begin
      // Any branch makes the current fetch wrong-path, aligned or not.
      kill_o = 1'b1;
      if (branch_target_i[1:0] == 2'b00) begin
        next_pc_o = branch_target_i;
      end else begin
        // PC holds; wait in FAULT for the exception logic's trap.
        misalign_set_o = 1'b1;
        next_state_o   = FAULT;
      end
    end else if (hs_i) begin
      next_pc_o = pc_i + INC_W;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator / instruction-fetch requester (IF stage).
//   clk_in, rst_n_in        : clock, async active-low reset
//   stall_in                : decode back-pressure, suppresses requests
//   branch_taken_in/target_in, trap_in/trap_vec_in : redirects
//   ireq (master)           : fetch request valid/ready/address
//   pc_plus_4_o             : fetch PC + INC
//   dec_pc_o / dec_valid_o  : PC of last accepted (non-killed) fetch, 1-cycle pulse
//   misalign_o              : 1-cycle pulse, branch target rejected
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = PC_INC
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            stall_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic            trap_in,
  input  logic [XLEN-1:0] trap_vec_in,
  pc_gen_if.master        ireq,
  output logic [XLEN-1:0] pc_plus_4_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic            dec_valid_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] dec_pc_q;
  logic            dec_valid_q, misalign_q;
  logic            hs, kill, misalign_set;

  assign ireq.ireq_valid_o = (state_q == FETCH) && !stall_in;
  assign ireq.iaddr_o      = fetch_pc_q;
  assign hs                = ireq.ireq_valid_o && ireq.ireq_ready_in;

  assign pc_plus_4_o = fetch_pc_q + INC_W;
  assign dec_pc_o    = dec_pc_q;
  assign dec_valid_o = dec_valid_q;
  assign misalign_o  = misalign_q;

  pc_next_sel #(.XLEN(XLEN), .INC(INC)) u_sel (
    .state_i         (state_q),
    .pc_i            (fetch_pc_q),
    .hs_i            (hs),
    .trap_i          (trap_in),
    .trap_vec_i      (trap_vec_in),
    .branch_taken_i  (branch_taken_in),
    .branch_target_i (branch_target_in),
    .next_pc_o       (fetch_pc_d),
    .next_state_o    (state_d),
    .kill_o          (kill),
    .misalign_set_o  (misalign_set)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_VEC;
      dec_pc_q    <= '0;
      dec_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      misalign_q  <= misalign_set;
      dec_valid_q <= hs && !kill;
      if (hs && !kill) dec_pc_q <= fetch_pc_q;
    end
  end

endmodule
